// File: rtl/scramble_inputs.sv
// ---------------------------------------------------------------------------
// scramble_inputs
//   Input conditioning stage in front of the Scramble core's button_in port.
//   Decodes PS/2 key events, merges both joysticks, remaps directions when the
//   display is rotated, and turns start/coin requests into coin pulses that
//   are timed in video frames (vblank rising edges).
//
// Ports
//   clk         system clock (only clock domain)
//   RESET       asynchronous, active-high reset
//   ps2_key     hps_io key event: [10] toggle, [9] pressed, [8] ext, [7:0] code
//   joystick_0  player 1 joystick, active-high
//   joystick_1  player 2 joystick, active-high
//   rotate      1 = horizontal display, remap directions
//   vblank      core vertical blank, synchronous to clk
//   button_n    registered, active-low
//               {fire2, start2, fire1, coin, start1, right, left, down, up}
//   coin_busy   coin sequencer is not idle
// ---------------------------------------------------------------------------
module scramble_inputs #(
  parameter int unsigned COIN_FRAMES     = 4,  // 1..255
  parameter int unsigned COIN_GAP_FRAMES = 4   // 1..255
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  input  logic        vblank,
  output logic [8:0]  button_n,
  output logic        coin_busy
);

  localparam logic [7:0] COIN_LOAD = 8'(COIN_FRAMES);
  localparam logic [7:0] GAP_LOAD  = 8'(COIN_GAP_FRAMES);

  // Key register indices
  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;
  localparam int K_CTRL  = 4;
  localparam int K_SPACE = 5;
  localparam int K_F1    = 6;
  localparam int K_F2    = 7;
  localparam int K_FIVE  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_GAP
  } coin_state_t;

  // -------------------------------------------------------------------------
  // PS/2 key decode
  // -------------------------------------------------------------------------
  logic       tog_q;
  logic       key_evt;
  logic [8:0] key_q;
  logic [8:0] key_hit;

  // hps_io signals a new event by flipping the toggle bit
  assign key_evt = ps2_key[10] ^ tog_q;

  always_comb begin
    key_hit = '0;
    // Arrow keys ignore the extended flag so a release with a different
    // [8] value still clears them.
    key_hit[K_UP]    = (ps2_key[7:0] == 8'h75);
    key_hit[K_DOWN]  = (ps2_key[7:0] == 8'h72);
    key_hit[K_LEFT]  = (ps2_key[7:0] == 8'h6B);
    key_hit[K_RIGHT] = (ps2_key[7:0] == 8'h74);
    key_hit[K_CTRL]  = (ps2_key[8:0] == 9'h014);
    key_hit[K_SPACE] = (ps2_key[8:0] == 9'h029);
    key_hit[K_F1]    = (ps2_key[8:0] == 9'h005);
    key_hit[K_F2]    = (ps2_key[8:0] == 9'h006);
    key_hit[K_FIVE]  = (ps2_key[8:0] == 9'h02E);
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      tog_q <= 1'b0;
      key_q <= '0;
    end else begin
      tog_q <= ps2_key[10];
      for (int i = 0; i < 9; i++) begin
        if (key_evt && key_hit[i]) begin
          key_q[i] <= ps2_key[9];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Button merge and orientation remap
  // -------------------------------------------------------------------------
  logic [15:0] joy;
  logic        up, down, left, right;
  logic        fire1, fire2, start1, start2;
  logic        req_lvl;
  logic        unused_joy;

  assign joy        = joystick_0 | joystick_1;
  assign unused_joy = ^joy[15:9];

  always_comb begin
    if (rotate) begin
      up    = key_q[K_LEFT]  | joy[1];
      down  = key_q[K_RIGHT] | joy[0];
      left  = key_q[K_DOWN]  | joy[2];
      right = key_q[K_UP]    | joy[3];
    end else begin
      up    = key_q[K_UP]    | joy[3];
      down  = key_q[K_DOWN]  | joy[2];
      left  = key_q[K_LEFT]  | joy[1];
      right = key_q[K_RIGHT] | joy[0];
    end
  end

  assign fire1   = key_q[K_CTRL]  | joy[4];
  assign fire2   = key_q[K_SPACE] | joy[5];
  assign start1  = key_q[K_F1]    | joy[6];
  assign start2  = key_q[K_F2]    | joy[7];
  assign req_lvl = start1 | start2 | key_q[K_FIVE] | joy[8];

  // -------------------------------------------------------------------------
  // Coin pulse sequencer and output register
  // -------------------------------------------------------------------------
  coin_state_t state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_dec;
  logic        pend_q;
  logic        req_q;
  logic        vblank_q;
  logic        req_rise;
  logic        frame_tick;

  assign req_rise   = req_lvl & ~req_q;
  assign frame_tick = vblank & ~vblank_q;
  // Saturating decrement: the counter never wraps below zero
  assign cnt_dec    = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
  assign coin_busy  = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      pend_q   <= 1'b0;
      req_q    <= 1'b0;
      vblank_q <= 1'b0;
      button_n <= 9'h1FF;
    end else begin
      req_q    <= req_lvl;
      vblank_q <= vblank;
      button_n <= ~{fire2, start2, fire1, (state_q == ST_ACTIVE),
                    start1, right, left, down, up};

      case (state_q)
        ST_IDLE: begin
          // A request beats a simultaneous frame tick: load, no decrement
          if (req_rise) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= COIN_LOAD;
          end
        end

        ST_ACTIVE: begin
          if (req_rise) begin
            pend_q <= 1'b1;
          end
          if (frame_tick) begin
            if (cnt_dec == 8'd0) begin
              state_q <= ST_GAP;
              cnt_q   <= GAP_LOAD;
            end else begin
              cnt_q <= cnt_dec;
            end
          end
        end

        ST_GAP: begin
          if (frame_tick && (cnt_dec == 8'd0)) begin
            // A request landing on the final gap tick counts as pending
            if (pend_q || req_rise) begin
              state_q <= ST_ACTIVE;
              cnt_q   <= COIN_LOAD;
            end else begin
              state_q <= ST_IDLE;
              cnt_q   <= 8'd0;
            end
            pend_q <= 1'b0;
          end else begin
            if (frame_tick) begin
              cnt_q <= cnt_dec;
            end
            if (req_rise) begin
              pend_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 8'd0;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scramble_inputs.sv
// ---------------------------------------------------------------------------
// tb_scramble_inputs
//   Self-checking bench for scramble_inputs. A behavioural model tracks held
//   keys by name, the coin sequence as a phase plus a count of frames seen,
//   and predicts button_n / coin_busy every clock.
// ---------------------------------------------------------------------------
module tb_scramble_inputs;

  localparam int COIN_F = 4;
  localparam int GAP_F  = 4;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic [10:0] ps2_key = '0;
  logic [15:0] joystick_0 = '0;
  logic [15:0] joystick_1 = '0;
  logic        rotate = 1'b0;
  logic        vblank = 1'b0;
  logic [8:0]  button_n;
  logic        coin_busy;

  int n_checks = 0;
  int n_fail   = 0;

  scramble_inputs #(
    .COIN_FRAMES    (COIN_F),
    .COIN_GAP_FRAMES(GAP_F)
  ) dut (
    .clk       (clk),
    .RESET     (RESET),
    .ps2_key   (ps2_key),
    .joystick_0(joystick_0),
    .joystick_1(joystick_1),
    .rotate    (rotate),
    .vblank    (vblank),
    .button_n  (button_n),
    .coin_busy (coin_busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit m_up, m_down, m_left, m_right, m_ctrl, m_space, m_f1, m_f2, m_five;
  bit m_tog, m_req, m_vb, m_pend;
  int m_phase;   // 0 idle, 1 coin held, 2 gap
  int m_frames;  // frames seen in the current phase
  logic [8:0] exp_btn;
  logic       exp_busy;

  task automatic model_reset();
    {m_up, m_down, m_left, m_right, m_ctrl, m_space, m_f1, m_f2, m_five} = '0;
    m_tog = 0; m_req = 0; m_vb = 0; m_pend = 0;
    m_phase = 0; m_frames = 0;
    exp_btn = 9'h1FF; exp_busy = 1'b0;
  endtask

  // Advance one clock: predict from what the DUT sees at this edge, then
  // wait for the edge and settle.
  task automatic tick();
    logic [15:0] joy;
    bit up, down, left, right, s1, s2, req, rise, frame;
    joy = joystick_0 | joystick_1;
    if (!rotate) begin
      up = m_up | joy[3]; down = m_down | joy[2];
      left = m_left | joy[1]; right = m_right | joy[0];
    end else begin
      up = m_left | joy[1]; down = m_right | joy[0];
      left = m_down | joy[2]; right = m_up | joy[3];
    end
    s1 = m_f1 | joy[6];
    s2 = m_f2 | joy[7];
    exp_btn = ~{m_space | joy[5], s2, m_ctrl | joy[4], (m_phase == 1),
                s1, right, left, down, up};

    req   = s1 | s2 | m_five | joy[8];
    rise  = req && !m_req;
    frame = vblank && !m_vb;
    m_req = req;
    m_vb  = vblank;

    if (ps2_key[10] != m_tog) begin
      case (ps2_key[7:0])
        8'h75: m_up    = ps2_key[9];
        8'h72: m_down  = ps2_key[9];
        8'h6B: m_left  = ps2_key[9];
        8'h74: m_right = ps2_key[9];
        default: ;
      endcase
      case (ps2_key[8:0])
        9'h014: m_ctrl  = ps2_key[9];
        9'h029: m_space = ps2_key[9];
        9'h005: m_f1    = ps2_key[9];
        9'h006: m_f2    = ps2_key[9];
        9'h02E: m_five  = ps2_key[9];
        default: ;
      endcase
    end
    m_tog = ps2_key[10];

    case (m_phase)
      0: if (rise) begin m_phase = 1; m_frames = 0; end
      1: begin
        if (rise) m_pend = 1;
        if (frame) begin
          m_frames++;
          if (m_frames == COIN_F) begin m_phase = 2; m_frames = 0; end
        end
      end
      default: begin
        if (frame && (m_frames + 1 == GAP_F)) begin
          m_phase  = (m_pend || rise) ? 1 : 0;
          m_frames = 0;
          m_pend   = 0;
        end else begin
          if (frame) m_frames++;
          if (rise) m_pend = 1;
        end
      end
    endcase
    exp_busy = (m_phase != 0);

    @(posedge clk);
    #1;
  endtask

  task automatic ps2_event(input bit pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (button_n !== 9'h1FF) begin
      n_fail++; $display("FAIL reset_held_btn: got %h want 1ff", button_n);
    end
    n_checks++;
    if (coin_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_held_busy: got %b want 0", coin_busy);
    end
    model_reset();
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (button_n !== exp_btn || coin_busy !== exp_busy) begin
        n_fail++;
        $display("FAIL reset_release: got %h/%b want %h/%b",
                 button_n, coin_busy, exp_btn, exp_busy);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_arrow_keys();
    logic [8:0] codes [6];
    logic [8:0] c;
    codes = '{9'h075, 9'h072, 9'h06B, 9'h074, 9'h014, 9'h029};
    rotate = 1'b0;
    ps2_event(1'b1, 9'h075);
    tick();
    n_checks++;
    if (button_n !== 9'h1FF) begin
      n_fail++; $display("FAIL up_press_1clk: got %h want 1ff", button_n);
    end
    tick();
    n_checks++;
    if (button_n !== 9'h1FE) begin
      n_fail++; $display("FAIL up_press_2clk: got %h want 1fe", button_n);
    end
    ps2_event(1'b0, 9'h175);
    tick(); tick();
    n_checks++;
    if (button_n !== 9'h1FF) begin
      n_fail++; $display("FAIL up_release_ext: got %h want 1ff", button_n);
    end
    for (int k = 0; k < 10; k++) begin
      c = codes[$urandom_range(0, 5)];
      if (c[7:0] != 8'h14 && c[7:0] != 8'h29) c[8] = 1'($urandom_range(0, 1));
      rotate = 1'($urandom_range(0, 1));
      ps2_event(1'b1, c);
      tick(); tick();
      n_checks++;
      if (button_n !== exp_btn) begin
        n_fail++; $display("FAIL key_press code=%h rot=%b: got %h want %h",
                           c, rotate, button_n, exp_btn);
      end
      c[8] = (c[7:0] == 8'h14 || c[7:0] == 8'h29) ? c[8] : ~c[8];
      ps2_event(1'b0, c);
      tick(); tick();
      n_checks++;
      if (button_n !== exp_btn) begin
        n_fail++; $display("FAIL key_release code=%h: got %h want %h",
                           c, button_n, exp_btn);
      end
      $display("key %h rot=%b checked", c, rotate);
    end
    rotate = 1'b0;
    tick();
  endtask

  task automatic test_rotation();
    rotate = 1'b1;
    joystick_1[3] = 1'b1;
    tick();
    n_checks++;
    if (button_n !== 9'h1F7 || button_n !== exp_btn) begin
      n_fail++; $display("FAIL rotate_on: got %h want 1f7 (model %h)", button_n, exp_btn);
    end
    rotate = 1'b0;
    tick();
    n_checks++;
    if (button_n !== 9'h1FE || button_n !== exp_btn) begin
      n_fail++; $display("FAIL rotate_off: got %h want 1fe (model %h)", button_n, exp_btn);
    end
    joystick_1[3] = 1'b0;
    tick();
    $display("test_rotation done");
  endtask

  task automatic test_coin_pulse();
    int pulses = 0;
    logic prev = 1'b1;
    ps2_event(1'b1, 9'h005);
    for (int c = 0; c < 120; c++) begin
      vblank = (c >= 6) && ((c % 8) < 2);
      tick();
      n_checks++;
      if (button_n !== exp_btn || coin_busy !== exp_busy) begin
        n_fail++; $display("FAIL coin_cycle %0d: got %h/%b want %h/%b",
                           c, button_n, coin_busy, exp_btn, exp_busy);
      end
      if (c == 1) begin
        n_checks++;
        if (button_n !== 9'h1EF) begin
          n_fail++; $display("FAIL start1_latency: got %h want 1ef", button_n);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (button_n !== 9'h1CF) begin
          n_fail++; $display("FAIL coin_latency: got %h want 1cf", button_n);
        end
      end
      if (prev && !button_n[5]) pulses++;
      prev = button_n[5];
      if (c == 20) ps2_event(1'b0, 9'h005);
    end
    vblank = 1'b0;
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL coin_pulse_count: got %0d want 1", pulses);
    end
    n_checks++;
    if (coin_busy !== 1'b0) begin
      n_fail++; $display("FAIL coin_idle: got busy %b want 0", coin_busy);
    end
    $display("test_coin_pulse: %0d pulse(s)", pulses);
  endtask

  task automatic test_coalesce();
    int pulses = 0;
    logic prev = 1'b1;
    for (int c = 0; c < 200; c++) begin
      joystick_0[8] = (c == 0);
      joystick_1[8] = (c == 3 || c == 5 || c == 7);
      vblank = (c >= 10) && ((c % 8) < 2);
      tick();
      n_checks++;
      if (button_n !== exp_btn || coin_busy !== exp_busy) begin
        n_fail++; $display("FAIL coalesce_cycle %0d: got %h/%b want %h/%b",
                           c, button_n, coin_busy, exp_btn, exp_busy);
      end
      if (prev && !button_n[5]) pulses++;
      prev = button_n[5];
    end
    vblank = 1'b0;
    n_checks++;
    if (pulses != 2) begin
      n_fail++; $display("FAIL coalesce_pulses: got %0d want 2", pulses);
    end
    n_checks++;
    if (coin_busy !== 1'b0) begin
      n_fail++; $display("FAIL coalesce_idle: got busy %b want 0", coin_busy);
    end
    $display("test_coalesce: %0d pulse(s)", pulses);
  endtask

  task automatic test_reset_mid_active();
    int pulses = 0;
    joystick_0[8] = 1'b1;
    tick();
    joystick_0[8] = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (button_n[5] !== 1'b0 || coin_busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_active_setup: got %h/%b want coin low, busy 1",
                         button_n, coin_busy);
    end
    #2;
    RESET = 1'b1;
    #1;
    n_checks++;
    if (button_n !== 9'h1FF || coin_busy !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got %h/%b want 1ff/0", button_n, coin_busy);
    end
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    RESET = 1'b0;
    for (int c = 0; c < 20; c++) begin
      vblank = (c % 8) < 2;
      tick();
      if (!button_n[5]) pulses++;
      n_checks++;
      if (button_n !== exp_btn || coin_busy !== exp_busy) begin
        n_fail++; $display("FAIL post_reset %0d: got %h/%b want %h/%b",
                           c, button_n, coin_busy, exp_btn, exp_busy);
      end
    end
    vblank = 1'b0;
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL post_reset_pulse: got %0d coin cycles want 0", pulses);
    end
    joystick_0[8] = 1'b1;
    tick();
    joystick_0[8] = 1'b0;
    tick();
    n_checks++;
    if (button_n !== 9'h1DF || button_n !== exp_btn) begin
      n_fail++; $display("FAIL post_reset_request: got %h want 1df", button_n);
    end
    $display("test_reset_mid_active done");
  endtask

  task automatic test_random();
    logic [8:0] codes [12];
    codes = '{9'h075, 9'h175, 9'h072, 9'h172, 9'h06B, 9'h074,
              9'h029, 9'h014, 9'h005, 9'h006, 9'h02E, 9'h129};
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        int b = $urandom_range(0, 8);
        if ($urandom_range(0, 1) == 0) joystick_0[b] = ~joystick_0[b];
        else                           joystick_1[b] = ~joystick_1[b];
      end
      if ($urandom_range(0, 31) == 0) rotate = ~rotate;
      if ($urandom_range(0, 4) == 0) vblank = ~vblank;
      if ($urandom_range(0, 5) == 0)
        ps2_event(1'($urandom_range(0, 1)), codes[$urandom_range(0, 11)]);
      tick();
      n_checks++;
      if (button_n !== exp_btn || coin_busy !== exp_busy) begin
        n_fail++; $display("FAIL random %0d: got %h/%b want %h/%b",
                           c, button_n, coin_busy, exp_btn, exp_busy);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_arrow_keys();
    test_rotation();
    test_coin_pulse();
    test_coalesce();
    test_reset_mid_active();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
